// File: rtl/mux_scan_collector_pkg.sv
// Shared definitions for the mux scan collector: FSM encoding, mux geometry
// and the scan start/end index helper.
package mux_scan_collector_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int NUM_INPUTS = 8;
   localparam int SEL_W      = 3;

   // First index of a scan in the given direction; the opposite direction's
   // first index is this direction's last.
   function automatic logic [SEL_W-1:0] first_index(input bit msb_first);
      return msb_first ? SEL_W'(NUM_INPUTS - 1) : '0;
   endfunction

endpackage

// File: rtl/mux8x1_1b.sv
// Single-bit 8:1 result multiplexer whose select is driven by the collector.
module mux8x1_1b (
   input  logic [7:0] i_in,
   input  logic [2:0] i_sel,
   output logic       o_out
);

   assign o_out = i_in[i_sel];

endmodule

// File: rtl/scan_index_counter.sv
// Scan bit index with a per-slot settle down-counter; advances one index per
// slot and parks on the last index instead of wrapping.
module scan_index_counter
   import mux_scan_collector_pkg::*;
#(
   parameter int SETTLE_CYCLES = 0,
   parameter bit MSB_FIRST     = 1'b0
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_load,
   input  logic             i_step,
   output logic [SEL_W-1:0] o_idx,
   output logic             o_advance,
   output logic             o_last
);

   localparam logic [SEL_W-1:0] FIRST_IDX = first_index(MSB_FIRST);
   localparam logic [SEL_W-1:0] LAST_IDX  = first_index(!MSB_FIRST);
   localparam logic [3:0]       SETTLE    = 4'(SETTLE_CYCLES);

   logic [SEL_W-1:0] r_idx;
   logic [3:0]       r_settle;
   logic             w_last;

   assign w_last    = (r_idx == LAST_IDX);
   assign o_idx     = r_idx;
   assign o_last    = w_last;
   assign o_advance = i_step && (r_settle == 4'd0);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_idx    <= FIRST_IDX;
         r_settle <= 4'd0;
      end else if (i_load) begin
         r_idx    <= FIRST_IDX;
         r_settle <= SETTLE;
      end else if (i_step) begin
         if (r_settle != 4'd0) begin
            r_settle <= r_settle - 4'd1;
         end else begin
            r_settle <= SETTLE;
            if (!w_last)
               r_idx <= MSB_FIRST ? r_idx - 3'd1 : r_idx + 3'd1;
         end
      end
   end

endmodule

// File: rtl/mux_scan_collector.sv
// Steps the 8:1 mux select through every input, captures each 1-bit result
// into a byte with its popcount, and offers the byte on a valid/ready port.
module mux_scan_collector
   import mux_scan_collector_pkg::*;
#(
   parameter int SETTLE_CYCLES = 0,
   parameter bit MSB_FIRST     = 1'b0
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic             i_res,
   output logic [SEL_W-1:0] o_sel,
   output logic             o_busy,
   output logic [7:0]       o_data_out,
   output logic [3:0]       o_ones,
   output logic             o_valid,
   input  logic             i_ready
);

   state_t           r_state;
   logic [7:0]       r_word;
   logic [3:0]       r_ones;
   logic             r_busy;
   logic             r_valid;

   logic             w_load;
   logic             w_step;
   logic             w_advance;
   logic             w_last;
   logic [SEL_W-1:0] w_idx;

   // The index reloads both when a scan starts and when the word is taken,
   // so sel is back at its reset value whenever the FSM is idle.
   assign w_load = ((r_state == ST_IDLE) && i_start) ||
                   ((r_state == ST_DONE) && i_ready);
   assign w_step = (r_state == ST_SCAN);

   scan_index_counter #(
      .SETTLE_CYCLES (SETTLE_CYCLES),
      .MSB_FIRST     (MSB_FIRST)
   ) u_index (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_load    (w_load),
      .i_step    (w_step),
      .o_idx     (w_idx),
      .o_advance (w_advance),
      .o_last    (w_last)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
         r_word  <= 8'h00;
         r_ones  <= 4'd0;
         r_busy  <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_state <= ST_SCAN;
                  r_word  <= 8'h00;
                  r_ones  <= 4'd0;
                  r_busy  <= 1'b1;
               end
            end
            ST_SCAN: begin
               if (w_advance) begin
                  r_word[w_idx] <= i_res;
                  r_ones        <= r_ones + {3'd0, i_res};
                  if (w_last) begin
                     r_state <= ST_DONE;
                     r_busy  <= 1'b0;
                     r_valid <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               if (i_ready) begin
                  r_state <= ST_IDLE;
                  r_valid <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   assign o_sel      = w_idx;
   assign o_busy     = r_busy;
   assign o_data_out = r_word;
   assign o_ones     = r_ones;
   assign o_valid    = r_valid;

endmodule

// File: tb/tb_mux_scan_collector.sv
// Directed bench: two collectors (LSB-first/no settle, MSB-first/settle 2),
// each reading back through an 8:1 mux, with an expected-word scoreboard.
module tb_mux_scan_collector;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] a_in,   b_in;
   logic [2:0] a_sel,  b_sel;
   logic       a_res,  b_res;
   logic       a_start, b_start;
   logic       a_ready, b_ready;
   logic       a_busy, b_busy;
   logic       a_valid, b_valid;
   logic [7:0] a_data, b_data;
   logic [3:0] a_ones, b_ones;

   typedef struct packed {
      logic [7:0] w;
      logic [3:0] n;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   mux8x1_1b mux_a (.i_in(a_in), .i_sel(a_sel), .o_out(a_res));
   mux8x1_1b mux_b (.i_in(b_in), .i_sel(b_sel), .o_out(b_res));

   mux_scan_collector #(.SETTLE_CYCLES(0), .MSB_FIRST(1'b0)) dut_a (
      .i_clk(clk), .i_reset(rst), .i_start(a_start), .i_res(a_res),
      .o_sel(a_sel), .o_busy(a_busy), .o_data_out(a_data), .o_ones(a_ones),
      .o_valid(a_valid), .i_ready(a_ready)
   );

   mux_scan_collector #(.SETTLE_CYCLES(2), .MSB_FIRST(1'b1)) dut_b (
      .i_clk(clk), .i_reset(rst), .i_start(b_start), .i_res(b_res),
      .o_sel(b_sel), .o_busy(b_busy), .o_data_out(b_data), .o_ones(b_ones),
      .o_valid(b_valid), .i_ready(b_ready)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic exp_t model(input logic [7:0] ins);
      exp_t e;
      e.w = ins;
      e.n = 4'($countones(ins));
      return e;
   endfunction

   task automatic pop_a(input string tag);
      exp_t e;
      chk({tag, "_sb_depth"}, q_a.size(), 1);
      if (q_a.size() > 0) begin
         e = q_a.pop_front();
         chk({tag, "_data"}, a_data, e.w);
         chk({tag, "_ones"}, a_ones, e.n);
      end
   endtask

   task automatic pop_b(input string tag);
      exp_t e;
      chk({tag, "_sb_depth"}, q_b.size(), 1);
      if (q_b.size() > 0) begin
         e = q_b.pop_front();
         chk({tag, "_data"}, b_data, e.w);
         chk({tag, "_ones"}, b_ones, e.n);
      end
   endtask

   task automatic wait_valid_a(input string tag, input int budget);
      int n = 0;
      while (!a_valid && n < budget) begin
         tick();
         n++;
      end
      chk({tag, "_valid_in_time"}, a_valid, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      a_in = 8'h00; b_in = 8'h00;
      a_start = 1'b0; b_start = 1'b0;
      a_ready = 1'b0; b_ready = 1'b0;
      tick();
      tick();

      chk("rst_a_sel",   a_sel,   0);
      chk("rst_a_busy",  a_busy,  0);
      chk("rst_a_valid", a_valid, 0);
      chk("rst_a_data",  a_data,  0);
      chk("rst_a_ones",  a_ones,  0);
      chk("rst_b_sel",   b_sel,   7);
      chk("rst_b_valid", b_valid, 0);
      rst = 1'b0;
      tick();

      // LSB-first, no settle: one sel step per cycle, word after 8 edges.
      a_in = 8'h82; a_ready = 1'b1; a_start = 1'b1;
      q_a.push_back(model(a_in));
      tick();
      a_start = 1'b0;
      chk("t1_busy", a_busy, 1);
      chk("t1_sel0", a_sel, 0);
      for (int k = 1; k < 8; k++) begin
         tick();
         chk("t1_sel", a_sel, k);
         chk("t1_no_valid", a_valid, 0);
      end
      tick();
      chk("t1_valid", a_valid, 1);
      chk("t1_busy_low", a_busy, 0);
      chk("t1_sel_hold", a_sel, 7);
      pop_a("t1");
      tick();
      chk("t1_valid_drop", a_valid, 0);
      chk("t1_sel_back", a_sel, 0);
      chk("t1_data_kept", a_data, 8'h82);
      chk("t1_ones_kept", a_ones, 2);

      // MSB-first, settle 2: each sel held 3 cycles, word after 24 edges.
      b_in = 8'h82; b_ready = 1'b1; b_start = 1'b1;
      q_b.push_back(model(b_in));
      tick();
      b_start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         for (int c = 0; c < 3; c++) begin
            chk("t2_sel", b_sel, 7 - i);
            chk("t2_busy", b_busy, 1);
            chk("t2_no_valid", b_valid, 0);
            tick();
         end
      end
      chk("t2_valid", b_valid, 1);
      chk("t2_busy_low", b_busy, 0);
      chk("t2_sel_hold", b_sel, 0);
      pop_b("t2");
      tick();
      chk("t2_valid_drop", b_valid, 0);
      chk("t2_sel_back", b_sel, 7);

      // All ones, consumer stalls 5 cycles, start held high throughout.
      a_in = 8'hFF; a_ready = 1'b0; a_start = 1'b1;
      q_a.push_back(model(a_in));
      tick();
      chk("t3_busy", a_busy, 1);
      wait_valid_a("t3", 12);
      pop_a("t3");
      for (int i = 0; i < 5; i++) begin
         chk("t3_valid_held", a_valid, 1);
         chk("t3_data_held", a_data, 8'hFF);
         chk("t3_ones_held", a_ones, 8);
         if (i == 4) begin
            a_start = 1'b0;
            a_ready = 1'b1;
         end
         tick();
      end
      chk("t3_valid_drop", a_valid, 0);
      chk("t3_idle_busy", a_busy, 0);
      chk("t3_sel_back", a_sel, 0);
      tick();
      chk("t3_no_queued_start", a_busy, 0);

      // Reset in the 4th SCAN cycle aborts; the next scan is clean.
      a_in = 8'h0F; a_start = 1'b1;
      tick();
      a_start = 1'b0;
      tick();
      tick();
      tick();
      chk("t4_partial_scan", a_busy, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t4_busy",  a_busy,  0);
      chk("t4_valid", a_valid, 0);
      chk("t4_data",  a_data,  0);
      chk("t4_ones",  a_ones,  0);
      chk("t4_sel",   a_sel,   0);
      chk("t4_b_sel", b_sel,   7);
      a_start = 1'b1;
      q_a.push_back(model(a_in));
      tick();
      a_start = 1'b0;
      wait_valid_a("t4", 12);
      pop_a("t4");
      tick();
      chk("t4_valid_drop", a_valid, 0);

      // Back-to-back; start coincident with the handshake is ignored.
      a_in = 8'h82; a_start = 1'b1;
      q_a.push_back(model(a_in));
      tick();
      a_start = 1'b0;
      wait_valid_a("t5a", 12);
      pop_a("t5a");
      a_start = 1'b1;
      a_in = 8'h55;
      tick();
      chk("t5_handshake_idle", a_busy, 0);
      chk("t5_handshake_valid", a_valid, 0);
      chk("t5_handshake_sel", a_sel, 0);
      q_a.push_back(model(a_in));
      tick();
      a_start = 1'b0;
      chk("t5_second_busy", a_busy, 1);
      for (int k = 0; k < 8; k++) tick();
      chk("t5_second_valid", a_valid, 1);
      pop_a("t5b");
      tick();
      chk("t5_second_drop", a_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
